// File: rtl/mac_rx_frame_reader_pkg.sv
// Shared definitions for the MAC RX frame reader: descriptor layout, length limits,
// FSM encoding and the beat carried through the skid buffer.
package mac_rx_frame_reader_pkg;

   localparam int unsigned MIN_LEN_DEF  = 64;
   localparam int unsigned MAX_LEN_DEF  = 1518;
   localparam int unsigned DESC_ERR_BIT = 15;
   localparam int unsigned LEN_W        = 12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PTR_LAT = 2'd1,
      ST_FWD     = 2'd2,
      ST_DROP    = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [7:0] data;
   } rx_beat_t;

   // Bits [14:12] of the descriptor are reserved and ignored.
   function automatic logic [LEN_W-1:0] desc_len(input logic [15:0] desc);
      return desc[LEN_W-1:0];
   endfunction

   function automatic logic desc_err(input logic [15:0] desc);
      return desc[DESC_ERR_BIT];
   endfunction

endpackage

// File: rtl/mac_rx_frame_reader_skid_buf.sv
// Two-entry skid buffer between the data FIFO read pipeline and the byte output.
// Accepts a new beat while full if the head is leaving in the same cycle.
module frame_skid_buf
   import mac_rx_frame_reader_pkg::*;
(
   input  logic       clk,
   input  logic       rstn_sys,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  rx_beat_t   in_beat_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output rx_beat_t   out_beat_o,
   output logic [1:0] count_o
);

   rx_beat_t   ent_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       push;
   logic       pop;

   assign out_valid_o = (count_q != 2'd0);
   assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign out_beat_o  = out_valid_o ? ent_q[rd_ptr_q] : '0;
   assign count_o     = count_q;

   always_ff @(posedge clk or negedge rstn_sys) begin
      if (!rstn_sys) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            ent_q[wr_ptr_q] <= in_beat_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/mac_rx_frame_reader.sv
// Pops RX descriptors, forwards frames of legal length without error through a
// skid buffer with valid/ready, and drains everything else from the data FIFO.
module mac_rx_frame_reader
   import mac_rx_frame_reader_pkg::*;
#(
   parameter int unsigned MIN_LEN = MIN_LEN_DEF,
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic        clk,
   input  logic        rstn_sys,
   output logic        rx_ptr_fifo_rd,
   input  logic [15:0] rx_ptr_fifo_dout,
   input  logic        rx_ptr_fifo_empty,
   output logic        rx_data_fifo_rd,
   input  logic [7:0]  rx_data_fifo_dout,
   output logic        o_valid,
   input  logic        o_ready,
   output logic [7:0]  o_data,
   output logic        o_sop,
   output logic        o_eop,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   // state   | meaning
   // IDLE    | wait for a descriptor and pop it
   // PTR_LAT | descriptor on dout: latch length, decide forward/drop
   // FWD     | credit-limited data reads feeding the skid buffer
   // DROP    | read and discard len bytes, one per cycle

   localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   rx_state_e        state_q, state_d;
   logic [LEN_W-1:0] len_q, rd_cnt_q, len_in;
   logic             armed_q, fwd_rd_q, sop_tag_q, eop_tag_q;
   logic [15:0]      frame_cnt_q, drop_cnt_q;
   logic             accept, len_zero, last_rd, credit_ok, frame_inc, drop_inc;
   logic             skid_in_ready, skid_out_valid, skid_pop;
   logic [1:0]       skid_cnt;
   logic [2:0]       occupancy;
   rx_beat_t         skid_in, skid_out;

   assign len_in   = desc_len(rx_ptr_fifo_dout);
   assign accept   = !desc_err(rx_ptr_fifo_dout) && (len_in >= MIN_L) && (len_in <= MAX_L);
   assign len_zero = (len_q == '0);
   assign last_rd  = (rd_cnt_q == len_q - LEN_W'(1));

   // Beats already in the skid after this cycle's pop, plus the read whose data lands now.
   assign skid_pop  = skid_out_valid && o_ready;
   assign occupancy = {1'b0, skid_cnt} - {2'b00, skid_pop} + {2'b00, fwd_rd_q};
   assign credit_ok = skid_in_ready && (occupancy < 3'd2);

   assign frame_inc = skid_pop && skid_out.eop;
   assign drop_inc  = (state_q == ST_DROP) && (len_zero || last_rd);

   always_ff @(posedge clk or negedge rstn_sys) begin
      if (!rstn_sys) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (armed_q && !rx_ptr_fifo_empty) state_d = ST_PTR_LAT;
         ST_PTR_LAT: state_d = accept ? ST_FWD : ST_DROP;
         ST_FWD:     if (len_zero || (credit_ok && last_rd)) state_d = ST_IDLE;
         ST_DROP:    if (len_zero || last_rd) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_ptr_fifo_rd  = 1'b0;
      rx_data_fifo_rd = 1'b0;
      case (state_q)
         ST_IDLE: rx_ptr_fifo_rd  = armed_q && !rx_ptr_fifo_empty;
         ST_FWD:  rx_data_fifo_rd = !len_zero && credit_ok;
         ST_DROP: rx_data_fifo_rd = !len_zero;
         default: ;
      endcase
   end

   // armed_q keeps the descriptor pop quiet while reset is held.
   always_ff @(posedge clk or negedge rstn_sys) begin
      if (!rstn_sys) begin
         armed_q     <= 1'b0;
         len_q       <= '0;
         rd_cnt_q    <= '0;
         fwd_rd_q    <= 1'b0;
         sop_tag_q   <= 1'b0;
         eop_tag_q   <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         armed_q <= 1'b1;
         if (state_q == ST_PTR_LAT) begin
            len_q    <= len_in;
            rd_cnt_q <= '0;
         end else if (rx_data_fifo_rd) begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
         end
         fwd_rd_q  <= rx_data_fifo_rd && (state_q == ST_FWD);
         sop_tag_q <= (rd_cnt_q == '0);
         eop_tag_q <= last_rd;
         if (frame_inc && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (drop_inc && (drop_cnt_q != 16'hFFFF))   drop_cnt_q  <= drop_cnt_q + 16'd1;
      end
   end

   assign skid_in = '{sop: sop_tag_q, eop: eop_tag_q, data: rx_data_fifo_dout};

   frame_skid_buf u_skid (
      .clk         (clk),
      .rstn_sys    (rstn_sys),
      .in_valid_i  (fwd_rd_q),
      .in_ready_o  (skid_in_ready),
      .in_beat_i   (skid_in),
      .out_valid_o (skid_out_valid),
      .out_ready_i (o_ready),
      .out_beat_o  (skid_out),
      .count_o     (skid_cnt)
   );

   assign o_valid   = skid_out_valid;
   assign o_data    = skid_out.data;
   assign o_sop     = skid_out.sop;
   assign o_eop     = skid_out.eop;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
// Bench for mac_rx_frame_reader: behavioural pointer/data FIFOs, a byte scoreboard
// filled when frames are queued and emptied against the observed output stream.
module tb_mac_rx_frame_reader;

   logic        clk = 1'b0;
   logic        rstn_sys = 1'b0;
   logic        rx_ptr_fifo_rd, rx_data_fifo_rd;
   logic [15:0] rx_ptr_fifo_dout = 16'h0;
   logic        rx_ptr_fifo_empty = 1'b1;
   logic [7:0]  rx_data_fifo_dout = 8'h0;
   logic        o_valid, o_sop, o_eop;
   logic        o_ready = 1'b0;
   logic [7:0]  o_data;
   logic [15:0] frame_cnt, drop_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] ptr_q [$];
   logic [7:0]  data_q [$];
   logic [9:0]  exp_q [$];
   logic [9:0]  obs_q [$];
   int          rd_cyc_q [$];

   int       cyc = 0, n_data_rd = 0, underflow = 0, valid_seen = 0, stab_err = 0;
   int       ready_mode = 1;   // 0 low, 1 high, 2 pseudo-random
   logic     ptr_rd_l = 1'b0, data_rd_l = 1'b0, prev_stall = 1'b0;
   logic [9:0] prev_beat = '0;

   always #5 clk = ~clk;

   mac_rx_frame_reader dut (
      .clk               (clk),
      .rstn_sys          (rstn_sys),
      .rx_ptr_fifo_rd    (rx_ptr_fifo_rd),
      .rx_ptr_fifo_dout  (rx_ptr_fifo_dout),
      .rx_ptr_fifo_empty (rx_ptr_fifo_empty),
      .rx_data_fifo_rd   (rx_data_fifo_rd),
      .rx_data_fifo_dout (rx_data_fifo_dout),
      .o_valid           (o_valid),
      .o_ready           (o_ready),
      .o_data            (o_data),
      .o_sop             (o_sop),
      .o_eop             (o_eop),
      .frame_cnt         (frame_cnt),
      .drop_cnt          (drop_cnt)
   );

   // Input driver: updated just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      rx_ptr_fifo_empty = (ptr_q.size() == 0);
      if (ready_mode == 2)      o_ready = ($urandom_range(0, 2) != 0);
      else if (ready_mode == 1) o_ready = 1'b1;
      else                      o_ready = 1'b0;
   end

   // Output monitor and read-request sampler, away from the active edge.
   always @(negedge clk) begin
      ptr_rd_l  = rx_ptr_fifo_rd;
      data_rd_l = rx_data_fifo_rd;
      if (o_valid) valid_seen++;
      if (rstn_sys && prev_stall && (!o_valid || {o_sop, o_eop, o_data} != prev_beat)) stab_err++;
      if (o_valid && o_ready) obs_q.push_back({o_sop, o_eop, o_data});
      prev_stall = rstn_sys && o_valid && !o_ready;
      prev_beat  = {o_sop, o_eop, o_data};
   end

   // Standard (non-FWFT) FIFOs: dout changes on the edge that completes the read.
   always @(posedge clk) begin
      cyc++;
      if (ptr_rd_l) begin
         if (ptr_q.size() != 0) rx_ptr_fifo_dout <= ptr_q.pop_front();
         else underflow++;
      end
      if (data_rd_l) begin
         n_data_rd++;
         rd_cyc_q.push_back(cyc);
         if (data_q.size() != 0) rx_data_fifo_dout <= data_q.pop_front();
         else underflow++;
      end
   end

   task automatic push_frame(input logic [15:0] desc, input logic [7:0] seed);
      int         len;
      bit         fwd;
      logic [7:0] b;
      len = int'(desc[11:0]);
      fwd = !desc[15] && (len >= 64) && (len <= 1518);
      ptr_q.push_back(desc);
      for (int i = 0; i < len; i++) begin
         b = seed + 8'(i);
         data_q.push_back(b);
         if (fwd) exp_q.push_back({(i == 0), (i == len - 1), b});
      end
   endtask

   task automatic apply_reset();
      ready_mode = 1;
      rstn_sys   = 1'b0;
      repeat (3) @(negedge clk);
      ptr_q.delete();
      data_q.delete();
      exp_q.delete();
      obs_q.delete();
      rd_cyc_q.delete();
      rstn_sys = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_quiet(input int budget, output bit ok);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < budget) begin
         @(negedge clk);
         n++;
         if (ptr_q.size() == 0 && data_q.size() == 0 && !o_valid) quiet++;
         else quiet = 0;
      end
      ok = (quiet >= 4);
   endtask

   task automatic test_reset();
      rstn_sys = 1'b0;
      ptr_q.push_back(16'h0040);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_ptr_fifo_rd, rx_data_fifo_rd, o_valid, o_sop, o_eop} !== 5'b0)
         $display("FAIL reset_ctrl got %b want 00000", {rx_ptr_fifo_rd, rx_data_fifo_rd, o_valid, o_sop, o_eop});
      else n_pass++;
      n_checks++;
      if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0)
         $display("FAIL reset_cnt got %0d/%0d want 0/0", frame_cnt, drop_cnt);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit ok;
      int r0;
      logic [9:0] e, o;
      apply_reset();
      r0 = n_data_rd;
      push_frame(16'h0040, 8'h00);
      wait_quiet(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL basic_byte got %h want %h", o, e); else n_pass++;
      end
      n_checks++;
      if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
      n_checks++;
      if (n_data_rd - r0 != 64) $display("FAIL basic_reads got %0d want 64", n_data_rd - r0); else n_pass++;
      n_checks++;
      if (rd_cyc_q.size() != 64 || rd_cyc_q[63] - rd_cyc_q[0] != 63)
         $display("FAIL basic_rate got %0d reads over %0d cycles want 64 over 63", rd_cyc_q.size(), rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[0]);
      else n_pass++;
   endtask

   task automatic test_error_drop();
      bit ok;
      int r0, v0;
      apply_reset();
      r0 = n_data_rd;
      v0 = valid_seen;
      push_frame(16'h8040, 8'h40);
      wait_quiet(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL err_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (n_data_rd - r0 != 64) $display("FAIL err_reads got %0d want 64", n_data_rd - r0); else n_pass++;
      n_checks++;
      if (valid_seen != v0) $display("FAIL err_valid got %0d valid cycles want 0", valid_seen - v0); else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'd1 || frame_cnt !== 16'd0)
         $display("FAIL err_counts got drop %0d frame %0d want 1 0", drop_cnt, frame_cnt);
      else n_pass++;
   endtask

   task automatic test_len_bounds();
      bit ok;
      int r0, u0;
      logic [9:0] e, o;
      apply_reset();
      r0 = n_data_rd;
      u0 = underflow;
      push_frame(16'h003F, 8'h11);
      push_frame(16'h05EF, 8'h22);
      push_frame(16'h0040, 8'h33);
      push_frame(16'h05EE, 8'h44);
      wait_quiet(8000, ok);
      n_checks++;
      if (!ok) $display("FAIL len_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (n_data_rd - r0 != 63 + 1519 + 64 + 1518 || underflow != u0)
         $display("FAIL len_reads got %0d (underflow %0d) want 3164", n_data_rd - r0, underflow - u0);
      else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'd2 || frame_cnt !== 16'd2)
         $display("FAIL len_counts got drop %0d frame %0d want 2 2", drop_cnt, frame_cnt);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL len_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL len_byte got %h want %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_zero_len();
      bit ok;
      int r0;
      logic [9:0] e, o;
      apply_reset();
      r0 = n_data_rd;
      push_frame(16'h0000, 8'h00);
      push_frame(16'h8000, 8'h00);
      push_frame(16'h0040, 8'h5A);
      wait_quiet(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL zero_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (n_data_rd - r0 != 64) $display("FAIL zero_reads got %0d want 64", n_data_rd - r0); else n_pass++;
      n_checks++;
      if (drop_cnt !== 16'd2 || frame_cnt !== 16'd1)
         $display("FAIL zero_counts got drop %0d frame %0d want 2 1", drop_cnt, frame_cnt);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL zero_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL zero_byte got %h want %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int s0;
      logic [9:0] e, o;
      apply_reset();
      s0 = stab_err;
      ready_mode = 2;
      push_frame(16'h0064, 8'h80);
      wait_quiet(4000, ok);
      ready_mode = 1;
      n_checks++;
      if (!ok) $display("FAIL bp_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (stab_err != s0) $display("FAIL bp_stable got %0d unstable stalls want 0", stab_err - s0); else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL bp_byte got %h want %h", o, e); else n_pass++;
      end
      n_checks++;
      if (frame_cnt !== 16'd1) $display("FAIL bp_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [9:0] e, o;
      apply_reset();
      push_frame(16'h0040, 8'h10);
      push_frame(16'h0040, 8'h90);
      wait_quiet(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_timeout got busy want quiet"); else n_pass++;
      // Two cycles with no read (IDLE, PTR_LAT) between the frames: read cycles differ by 3.
      n_checks++;
      if (rd_cyc_q.size() != 128 || rd_cyc_q[64] - rd_cyc_q[63] != 3)
         $display("FAIL b2b_gap got %0d reads gap %0d want 128 gap 3", rd_cyc_q.size(), rd_cyc_q[64] - rd_cyc_q[63]);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 16'd2) $display("FAIL b2b_frame_cnt got %0d want 2", frame_cnt); else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL b2b_byte got %h want %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int r0, n;
      logic [9:0] e, o;
      r0 = n_data_rd;
      n  = 0;
      push_frame(16'h0040, 8'h20);
      while (n_data_rd - r0 < 30 && n < 500) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n_data_rd - r0 < 30) $display("FAIL mid_start got %0d reads want 30", n_data_rd - r0); else n_pass++;
      @(posedge clk);
      #2;
      rstn_sys = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rx_ptr_fifo_rd, rx_data_fifo_rd, o_valid, o_sop, o_eop} !== 5'b0 || o_data !== 8'h00)
         $display("FAIL mid_outputs got %b data %h want 00000 data 00",
                  {rx_ptr_fifo_rd, rx_data_fifo_rd, o_valid, o_sop, o_eop}, o_data);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0)
         $display("FAIL mid_counters got %0d/%0d want 0/0", frame_cnt, drop_cnt);
      else n_pass++;
      r0 = n_data_rd;
      repeat (2) @(negedge clk);
      ptr_q.delete();
      data_q.delete();
      exp_q.delete();
      obs_q.delete();
      rstn_sys = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (n_data_rd != r0) $display("FAIL mid_no_reads got %0d reads want 0", n_data_rd - r0); else n_pass++;
      push_frame(16'h0040, 8'h33);
      wait_quiet(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL mid_timeout got busy want quiet"); else n_pass++;
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL mid_count got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL mid_byte got %h want %h", o, e); else n_pass++;
      end
      n_checks++;
      if (frame_cnt !== 16'd1) $display("FAIL mid_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error_drop();
      test_len_bounds();
      test_zero_len();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
